// File: rtl/pipeline_sequencer_pkg.sv
// rtl/pipeline_sequencer_pkg.sv - shared constants and types for the pipeline sequencer
package pipeline_sequencer_pkg;

    localparam int PipelineHeight = 5;
    localparam int PipeDepth      = 13;
    localparam int HitCountWidth  = 16;
    localparam int CounterWidth   = 8;

    typedef logic [PipelineHeight-1:0] PixelArray;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pipeline_sequencer_hit_accumulator.sv
// rtl/pipeline_sequencer_hit_accumulator.sv - popcount, saturating hit counter and sticky hit flag
module hit_accumulator
    import pipeline_sequencer_pkg::*;
#(
    parameter int Width      = PipelineHeight,
    parameter int CountWidth = HitCountWidth
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [Width-1:0]      result_i,
    output logic [CountWidth-1:0] hit_count_o,
    output logic                  hit_any_o
);

    // One spare bit catches the carry so saturation is a single bit test.
    localparam int SumWidth = CountWidth + 1;

    logic [CountWidth-1:0] count_q, count_d;
    logic                  any_q, any_d;
    logic [SumWidth-1:0]   ones;
    logic [SumWidth-1:0]   sum;

    // Number of set detector bits in the accepted pixel column.
    always_comb begin
        ones = '0;
        for (int i = 0; i < Width; i++) begin
            ones = ones + SumWidth'(result_i[i]);
        end
    end

    // Clear wins over accept; the counter sticks at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        any_d   = any_q;
        sum     = SumWidth'(count_q) + ones;
        if (clear_i) begin
            count_d = '0;
            any_d   = 1'b0;
        end else if (accept_i) begin
            count_d = sum[SumWidth-1] ? '1 : sum[CountWidth-1:0];
            any_d   = any_q | (|result_i);
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            any_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            any_q   <= any_d;
        end
    end

    assign hit_count_o = count_q;
    assign hit_any_o   = any_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - frame sequencer driving a stallable detector pipeline
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int PipelineHeight = pipeline_sequencer_pkg::PipelineHeight,
    parameter int PipeDepth      = pipeline_sequencer_pkg::PipeDepth,
    parameter int FrameLength    = 256
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      out_ready,
    input  logic [PipelineHeight-1:0] result,
    output logic                      advance,
    output logic [CounterWidth-1:0]   counter,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done,
    output logic [HitCountWidth-1:0]  hit_count,
    output logic                      hit_any
);

    // Pixel index of the final pixel of a frame; 256 maps to 255.
    localparam logic [CounterWidth-1:0] LastIndex = CounterWidth'(FrameLength - 1);

    seq_state_e                state_q, state_d;
    logic [PipeDepth-1:0]      valid_q, valid_d;
    logic [PipeDepth-1:0]      valid_shift;
    logic [CounterWidth-1:0]   counter_q, counter_d;
    logic                      start_accept;
    logic                      accept;

    assign out_valid    = valid_q[PipeDepth-1];
    assign advance      = ((state_q == SEQ_RUN) || (state_q == SEQ_DRAIN)) && (!out_valid || out_ready);
    assign start_accept = (state_q == SEQ_IDLE) && start && !abort;
    assign accept       = out_valid && out_ready;
    assign busy         = (state_q != SEQ_IDLE);
    assign done         = (state_q == SEQ_DONE);
    assign counter      = counter_q;

    // Next state, valid pipe and pixel counter; abort overrides everything else.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        counter_d   = counter_q;
        valid_shift = (valid_q << 1) | PipeDepth'(state_q == SEQ_RUN);
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d   = SEQ_RUN;
                    counter_d = '0;
                end
            end
            SEQ_RUN: begin
                if (advance) begin
                    valid_d   = valid_shift;
                    counter_d = counter_q + CounterWidth'(1);
                    if (counter_q == LastIndex) begin
                        state_d = SEQ_DRAIN;
                    end
                end
            end
            SEQ_DRAIN: begin
                if (advance) begin
                    valid_d = valid_shift;
                    if (valid_shift == '0) begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
        if (abort) begin
            state_d   = SEQ_IDLE;
            valid_d   = '0;
            counter_d = counter_q;
        end
    end

    // State, valid pipe and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SEQ_IDLE;
            valid_q   <= '0;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            counter_q <= counter_d;
        end
    end

    hit_accumulator #(
        .Width      (PipelineHeight),
        .CountWidth (HitCountWidth)
    ) u_hits (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear_i     (start_accept),
        .accept_i    (accept),
        .result_i    (result),
        .hit_count_o (hit_count),
        .hit_any_o   (hit_any)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - self-checking bench for pipeline_sequencer
module tb_pipeline_sequencer;

    localparam int D  = 13;
    localparam int NI = 2;

    logic       clock = 1'b0;
    logic       reset_n, start, abort, out_ready;
    logic [4:0] result;

    logic       adv_w  [NI];
    logic       ov_w   [NI];
    logic       busy_w [NI];
    logic       done_w [NI];
    logic       ha_w   [NI];
    logic [7:0] cnt_w  [NI];
    logic [15:0] hc_w  [NI];

    logic        acc_rstn, acc_clear, acc_accept, acc_any;
    logic [4:0]  acc_result;
    logic [15:0] acc_count;
    bit          acc_done = 1'b0;

    int total = 0;
    int bad   = 0;

    // Frame-level reference: phase 0 idle / 1 active / 2 done, advances since start, hits.
    int ph [NI];
    int an [NI];
    int mc [NI];
    int mh [NI];
    bit ma [NI];

    always #5 clock = ~clock;

    pipeline_sequencer #(.PipelineHeight(5), .PipeDepth(D), .FrameLength(256)) u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .out_ready(out_ready),
        .result(result), .advance(adv_w[0]), .counter(cnt_w[0]), .out_valid(ov_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .hit_count(hc_w[0]), .hit_any(ha_w[0]));

    pipeline_sequencer #(.PipelineHeight(5), .PipeDepth(D), .FrameLength(1)) u_dut_fl1 (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .out_ready(out_ready),
        .result(result), .advance(adv_w[1]), .counter(cnt_w[1]), .out_valid(ov_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .hit_count(hc_w[1]), .hit_any(ha_w[1]));

    hit_accumulator #(.Width(5), .CountWidth(16)) u_acc (
        .clock(clock), .reset_n(acc_rstn), .clear_i(acc_clear), .accept_i(acc_accept),
        .result_i(acc_result), .hit_count_o(acc_count), .hit_any_o(acc_any));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int fl_of(input int k);
        return (k == 0) ? 256 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            ph[k] = 0; an[k] = 0; mc[k] = 0; mh[k] = 0; ma[k] = 1'b0;
        end
    endtask

    // Compare every output against the frame model, then move the model one cycle on.
    task automatic step_model();
        for (int k = 0; k < NI; k++) begin
            int fl;
            int pc;
            bit e_ov, e_adv;
            fl    = fl_of(k);
            e_ov  = (ph[k] == 1) && (an[k] >= D) && (an[k] < fl + D);
            e_adv = (ph[k] == 1) && (!e_ov || out_ready);
            check_eq($sformatf("advance[%0d]", k), adv_w[k], e_adv);
            check_eq($sformatf("out_valid[%0d]", k), ov_w[k], e_ov);
            check_eq($sformatf("counter[%0d]", k), cnt_w[k], mc[k]);
            check_eq($sformatf("busy[%0d]", k), busy_w[k], ph[k] != 0);
            check_eq($sformatf("done[%0d]", k), done_w[k], ph[k] == 2);
            check_eq($sformatf("hit_count[%0d]", k), hc_w[k], mh[k]);
            check_eq($sformatf("hit_any[%0d]", k), ha_w[k], ma[k]);
            if (e_ov && out_ready) begin
                pc    = $countones(result);
                mh[k] = (mh[k] + pc > 65535) ? 65535 : mh[k] + pc;
                if (result != 0) ma[k] = 1'b1;
            end
            if (!reset_n) begin
                ph[k] = 0; an[k] = 0; mc[k] = 0; mh[k] = 0; ma[k] = 1'b0;
            end else if (abort) begin
                ph[k] = 0;
            end else begin
                case (ph[k])
                    0: if (start) begin
                        ph[k] = 1; an[k] = 0; mc[k] = 0; mh[k] = 0; ma[k] = 1'b0;
                    end
                    1: if (e_adv) begin
                        an[k] = an[k] + 1;
                        mc[k] = ((an[k] < fl) ? an[k] : fl) % 256;
                        if (an[k] == fl + D) ph[k] = 2;
                    end
                    default: ph[k] = 0;
                endcase
            end
        end
    endtask

    task automatic run_cycle(input bit st, input bit ab, input bit rdy, input logic [4:0] res);
        @(posedge clock);
        #1;
        start = st; abort = ab; out_ready = rdy; result = res;
        @(negedge clock);
        step_model();
    endtask

    // Saturating accumulator exercised on its own: 20000 accepts of five hits each.
    initial begin
        acc_rstn = 1'b0; acc_clear = 1'b0; acc_accept = 1'b0; acc_result = 5'b11111;
        @(negedge clock);
        check_eq("acc_reset_count", acc_count, 16'h0000);
        check_eq("acc_reset_any", acc_any, 1'b0);
        @(posedge clock); #1; acc_rstn = 1'b1; acc_clear = 1'b1;
        @(posedge clock); #1; acc_clear = 1'b0; acc_accept = 1'b1;
        repeat (100) @(posedge clock);
        #1;
        check_eq("acc_100", acc_count, 16'd500);
        check_eq("acc_any", acc_any, 1'b1);
        acc_accept = 1'b0;
        @(posedge clock); #1;
        check_eq("acc_idle_ignored", acc_count, 16'd500);
        acc_accept = 1'b1;
        repeat (13007) @(posedge clock);
        #1;
        check_eq("acc_exact_max", acc_count, 16'hFFFF);
        @(posedge clock); #1;
        check_eq("acc_no_wrap", acc_count, 16'hFFFF);
        repeat (6892) @(posedge clock);
        #1;
        check_eq("acc_20000", acc_count, 16'hFFFF);
        acc_accept = 1'b0; acc_clear = 1'b1;
        @(posedge clock); #1;
        check_eq("acc_clear_count", acc_count, 16'h0000);
        check_eq("acc_clear_any", acc_any, 1'b0);
        acc_clear = 1'b0;
        acc_done  = 1'b1;
    end

    initial begin
        int first, last, nov, nacc, dcyc, ndone, f1, d1, nstall, first2;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; result = 5'd0;
        model_reset();
        repeat (2) begin
            @(negedge clock);
            step_model();
        end
        @(posedge clock); #3; reset_n = 1'b1;

        // Full frame, no stalls, constant 3-hit pattern.
        first = -1; last = -1; nov = 0; dcyc = -1; ndone = 0; f1 = -1; d1 = -1;
        for (int c = 0; c <= 272; c++) begin
            run_cycle(c == 0, 1'b0, 1'b1, 5'b10101);
            if (ov_w[0]) begin if (first < 0) first = c; last = c; nov++; end
            if (done_w[0]) begin dcyc = c; ndone++; end
            if (ov_w[1] && f1 < 0) f1 = c;
            if (done_w[1] && d1 < 0) d1 = c;
            if (c == 271) check_eq("s1_busy_271", busy_w[0], 1'b0);
        end
        check_eq("s1_first_valid", first, 14);
        check_eq("s1_last_valid", last, 269);
        check_eq("s1_valid_cycles", nov, 256);
        check_eq("s1_done_cycle", dcyc, 270);
        check_eq("s1_done_count", ndone, 1);
        check_eq("s1_hit_count", hc_w[0], 768);
        check_eq("s1_hit_any", ha_w[0], 1'b1);
        check_eq("fl1_first_valid", f1, 14);
        check_eq("fl1_done_cycle", d1, 15);
        check_eq("fl1_hit_count", hc_w[1], 3);

        // Downstream stall for cycles 20..24.
        first = -1; nacc = 0; dcyc = -1; nstall = 0;
        for (int c = 0; c <= 277; c++) begin
            bit rdy;
            rdy = !(c >= 20 && c <= 24);
            run_cycle(c == 0, 1'b0, rdy, 5'($urandom));
            if (ov_w[0] && first < 0) first = c;
            if (ov_w[0] && rdy) nacc++;
            if (done_w[0]) dcyc = c;
            if (!rdy && adv_w[0]) nstall++;
            if (c == 24) begin
                check_eq("s2_counter_frozen", cnt_w[0], 19);
                check_eq("s2_valid_held", ov_w[0], 1'b1);
            end
        end
        check_eq("s2_first_valid", first, 14);
        check_eq("s2_accepts", nacc, 256);
        check_eq("s2_stall_advances", nstall, 0);
        check_eq("s2_done_cycle", dcyc, 275);

        // Abort at cycle 100, restart at 102.
        ndone = 0; first2 = -1; dcyc = -1;
        for (int c = 0; c <= 374; c++) begin
            run_cycle(c == 0 || c == 102, c == 100, 1'b1, 5'($urandom));
            if (done_w[0] && c <= 101) ndone++;
            if (done_w[0]) dcyc = c;
            if (c > 102 && ov_w[0] && first2 < 0) first2 = c;
            if (c == 101) begin
                check_eq("s3_busy_101", busy_w[0], 1'b0);
                check_eq("s3_valid_101", ov_w[0], 1'b0);
            end
        end
        check_eq("s3_no_done_after_abort", ndone, 0);
        check_eq("s3_restart_first_valid", first2, 116);
        check_eq("s3_restart_done", dcyc, 372);

        // Start held high: one frame, the next begins only after returning to idle.
        ndone = 0; dcyc = -1;
        for (int c = 0; c <= 273; c++) begin
            run_cycle(1'b1, 1'b0, 1'b1, 5'($urandom));
            if (done_w[0] && c <= 271) begin ndone++; dcyc = c; end
            if (c == 271) check_eq("s4_busy_271", busy_w[0], 1'b0);
            if (c == 272) check_eq("s4_busy_272", busy_w[0], 1'b1);
        end
        check_eq("s4_done_count", ndone, 1);
        check_eq("s4_done_cycle", dcyc, 270);
        run_cycle(1'b0, 1'b1, 1'b1, 5'd0);
        run_cycle(1'b0, 1'b0, 1'b1, 5'd0);

        // Asynchronous reset in cycle 50 of a frame.
        for (int c = 0; c <= 49; c++) run_cycle(c == 0, 1'b0, 1'b1, 5'($urandom));
        @(posedge clock); #1; start = 1'b0; abort = 1'b0;
        #2; reset_n = 1'b0; #1;
        check_eq("rst_advance", adv_w[0], 1'b0);
        check_eq("rst_counter", cnt_w[0], 8'd0);
        check_eq("rst_out_valid", ov_w[0], 1'b0);
        check_eq("rst_busy", busy_w[0], 1'b0);
        check_eq("rst_done", done_w[0], 1'b0);
        check_eq("rst_hit_count", hc_w[0], 16'd0);
        check_eq("rst_hit_any", ha_w[0], 1'b0);
        model_reset();
        @(negedge clock);
        step_model();
        repeat (2) run_cycle(1'b0, 1'b0, 1'b1, 5'd0);
        @(posedge clock); #3; reset_n = 1'b1;
        first = -1; dcyc = -1;
        for (int c = 0; c <= 271; c++) begin
            run_cycle(c == 0, 1'b0, 1'b1, 5'($urandom));
            if (ov_w[0] && first < 0) first = c;
            if (done_w[0]) dcyc = c;
        end
        check_eq("s5_first_valid", first, 14);
        check_eq("s5_done_cycle", dcyc, 270);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0,
                      $urandom_range(0, 3) != 0, 5'($urandom));
        end

        for (int i = 0; i < 30000 && !acc_done; i++) @(posedge clock);
        check_eq("acc_finished", acc_done, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter PipelineHeight, default 5: number of parallel pixel rows; width of result.
REQ-002 SHALL have parameter PipeDepth, default 13: register stages from pixel issue to detector output.
REQ-003 SHALL have parameter FrameLength, default 256: pixels issued per frame, legal range 1..256.
REQ-004 SHALL have ports: clock  in  1  single clock, all logic on posedge.
REQ-005 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: start  in  1  request one frame; sampled only in IDLE.
REQ-007 SHALL have ports: abort  in  1  synchronous frame cancel.
REQ-008 SHALL have ports: out_ready  in  1  downstream (frame writer) accepts current output.
REQ-009 SHALL have ports: result  in  PipelineHeight  per-row detector bits, aligned with out_valid.
REQ-010 SHALL have ports: advance  out  1  clock enable for every pipeline stage.
REQ-011 SHALL have ports: counter  out  8  pixel index of the pixel issued when advance=1.
REQ-012 SHALL have ports: out_valid  out  1  pipeline output holds a real pixel.
REQ-013 SHALL have ports: busy  out  1  state is not IDLE.
REQ-014 SHALL have ports: done  out  1  one-cycle end-of-frame pulse.
REQ-015 SHALL have ports: hit_count  out  16  detector hits counted this frame.
REQ-016 SHALL have ports: hit_any  out  1  sticky, any hit this frame.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when the FrameLength-th pixel issues; DRAIN->DONE on the advance that empties the valid pipe; DONE->IDLE unconditionally.
REQ-018 SHALL drive advance = (state is RUN or DRAIN) and (not out_valid or out_ready): output stall freezes the whole pipeline.
REQ-019 SHALL keep a PipeDepth-bit valid shift register, shifted on advance; input bit 1 in RUN, 0 in DRAIN; out_valid = last bit.
REQ-020 SHALL increment counter on each advance in RUN, wrapping 255->0; counter cleared to 0 on accepted start.
REQ-021 SHALL give latency: with out_ready=1, start high in cycle 0 -> first advance in cycle 1 -> first out_valid in cycle 1+PipeDepth.
REQ-022 SHALL, on each accept (out_valid and out_ready), add popcount(result) to hit_count, saturating at 0xFFFF, and set hit_any if result is nonzero.
REQ-023 SHALL clear hit_count and hit_any on accepted start; hold both through DONE and IDLE until the next start.
REQ-024 SHALL assert done only in DONE, exactly one cycle, never after abort.
REQ-025 SHALL ignore start outside IDLE; abort has priority over start in the same cycle.
REQ-026 SHALL, on abort in any state, go to IDLE next cycle, clear the valid register and out_valid, keep hit_count/hit_any.
REQ-027 SHALL ignore result when out_valid=0.
REQ-028 SHALL, with FrameLength=1, go RUN->DRAIN after one issue.

Reset
REQ-029 SHALL on reset_n low immediately force: state IDLE, valid register 0, counter 0, advance 0, out_valid 0, busy 0, done 0, hit_count 0, hit_any 0.
REQ-030 SHALL treat reset mid-frame like abort but also clear counters; first start after release behaves as from power-up.

Structure
REQ-031 SHALL place PipelineHeight, PipeDepth, the state enum and the hit-count width in the shared pipeline package alongside PixelArray.
REQ-032 SHALL contain one sub-module, hit_accumulator (popcount plus saturating add plus sticky flag), instantiated once.

Verification
REQ-033 SHALL cover: FrameLength=256, out_ready=1, start pulse at cycle 0 -> out_valid cycles 14..269 (256 cycles), done in cycle 270 only, busy low from 271.
REQ-034 SHALL cover: out_ready low for cycles 20..24 -> advance low 20..24, counter and out_valid frozen, no pixel lost or duplicated, done at cycle 275.
REQ-035 SHALL cover: result=5'b10101 on every accept of 256 pixels -> hit_count=768, hit_any=1; result held 5'b11111 across FrameLength=256 over 52 frames without start clear impossible, so force a saturation case via 20000 accepts -> hit_count=0xFFFF.
REQ-036 SHALL cover: abort at cycle 100 -> IDLE at 101, out_valid 0 at 101, no done; start at 102 -> first out_valid at 116.
REQ-037 SHALL cover: start held high through an entire frame -> exactly one frame runs and a second starts only after DONE returns to IDLE.
REQ-038 SHALL cover: reset_n low at cycle 50 mid-frame -> all outputs at reset values asynchronously, before the next clock edge.
